// File: rtl/layer2_drv_pkg.sv
// Shared state encoding and lane geometry for the layer-2 convolution driver.
// The optional overlap build is selected with LAYER2_DRV_OVERLAP_EN.
package layer2_drv_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_FIRE,
      S_WAIT,
      S_CAPT,
      S_DRAIN
   } state_t;

   localparam int unsigned LANES_IN   = 16;
   localparam int unsigned LANES_OUT  = 32;
   localparam int unsigned W_LANES    = 32;
   localparam int unsigned LANE_SHIFT = 4;
   localparam int unsigned LANE_W     = 1 << LANE_SHIFT;
   localparam int unsigned IN_BUS_W   = LANES_IN  << LANE_SHIFT;
   localparam int unsigned OUT_BUS_W  = LANES_OUT << LANE_SHIFT;
   localparam int unsigned W_BUS_W    = W_LANES   << LANE_SHIFT;

endpackage

// File: rtl/layer2_word_packer.sv
// Word-serial to packed-bus shift-in: writes lane 0 first, flags full after the last lane.
// Clear rewinds the lane counter but keeps the stored words so the bus stays stable.
module layer2_word_packer
   import layer2_drv_pkg::*;
#(
   parameter int unsigned bits       = 16,
   parameter int unsigned bits_shift = LANE_SHIFT,
   parameter int unsigned lanes      = LANES_IN
) (
   input  logic                            clk_in,
   input  logic                            rst_n,
   input  logic                            i_wr,
   input  logic                            i_clr,
   input  logic [bits-1:0]                 i_data,
   output logic [(lanes<<bits_shift)-1:0]  o_vec,
   output logic                            o_full,
   output logic                            o_last
);

   localparam int unsigned CW = (lanes > 1) ? $clog2(lanes) : 1;

   logic [CW-1:0]                 r_cnt;
   logic                          r_full;
   logic [(lanes<<bits_shift)-1:0] r_vec;

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_full <= 1'b0;
         r_vec  <= '0;
      end else if (i_clr) begin
         r_cnt  <= '0;
         r_full <= 1'b0;
      end else if (i_wr && !r_full) begin
         r_vec[(int'(r_cnt) << bits_shift) +: bits] <= i_data;
         if (r_cnt == CW'(lanes - 1)) begin
            r_full <= 1'b1;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_vec  = r_vec;
   assign o_full = r_full;
   assign o_last = i_wr && !r_full && !i_clr && (r_cnt == CW'(lanes - 1));

endmodule

// File: rtl/layer2_conv_driver.sv
// Initiator for the layer-2 1x1 convolution array: weight bank, activation packing, start/capture/drain.
// Define LAYER2_DRV_OVERLAP_EN to add a shadow vector so the next pixel fills while the array runs.
module layer2_conv_driver
   import layer2_drv_pkg::*;
#(
   parameter int unsigned bits            = 16,
   parameter int unsigned bits_shift      = LANE_SHIFT,
   parameter int unsigned channel_in_num  = LANES_IN,
   parameter int unsigned channel_out_num = LANES_OUT,
   parameter int unsigned weight_num      = W_LANES,
   parameter int unsigned pixel_num       = 196
) (
   input  logic                                      clk_in,
   input  logic                                      rst_n,
   input  logic                                      frame_go,
   input  logic                                      w_valid,
   input  logic [bits-1:0]                           w_data,
   output logic                                      w_ready,
   input  logic                                      act_valid,
   input  logic [bits-1:0]                           act_data,
   output logic                                      act_ready,
   output logic [(channel_in_num<<bits_shift)-1:0]   conv_data_in,
   output logic [(weight_num<<bits_shift)-1:0]       conv_weights,
   output logic                                      conv_start,
   input  logic                                      conv_ready,
   input  logic [(channel_out_num<<bits_shift)-1:0]  conv_data_out,
   output logic                                      out_valid,
   output logic [(channel_out_num<<bits_shift)-1:0]  out_data,
   input  logic                                      out_ready,
   output logic                                      frame_done
);

   localparam int unsigned PW = (pixel_num > 1) ? $clog2(pixel_num) : 1;

`ifdef LAYER2_DRV_OVERLAP_EN
   localparam bit OVERLAP = 1'b1;
`else
   localparam bit OVERLAP = 1'b0;
`endif

   state_t                                   r_state;
   state_t                                   w_next;
   logic [PW-1:0]                            r_pix_cnt;
   logic [(channel_out_num<<bits_shift)-1:0] r_out_data;
   logic                                     r_frame_done;

   logic w_w_wr;
   logic w_wfull;
   logic w_wlast;
   logic w_act_wr;
   logic w_vec_room;
   logic w_fill_last;
   logic w_shadow_done;
   logic w_drain_hs;
   logic w_pix_last;

   assign w_w_wr     = w_valid && w_ready;
   assign w_act_wr   = act_valid && act_ready;
   assign w_drain_hs = (r_state == S_DRAIN) && out_ready;
   assign w_pix_last = (r_pix_cnt == PW'(pixel_num - 1));

   layer2_word_packer #(
      .bits       (bits),
      .bits_shift (bits_shift),
      .lanes      (weight_num)
   ) u_wbank (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .i_wr   (w_w_wr),
      .i_clr  (1'b0),
      .i_data (w_data),
      .o_vec  (conv_weights),
      .o_full (w_wfull),
      .o_last (w_wlast)
   );

`ifdef LAYER2_DRV_OVERLAP_EN
   // r_sel names the vector being fired; the other one is the shadow filled meanwhile.
   logic                                    r_sel;
   logic                                    w_tgt;
   logic                                    w_full_a, w_full_b, w_last_a, w_last_b;
   logic [(channel_in_num<<bits_shift)-1:0] w_vec_a, w_vec_b;

   assign w_tgt = (r_state == S_FILL) ? r_sel : !r_sel;

   layer2_word_packer #(
      .bits       (bits),
      .bits_shift (bits_shift),
      .lanes      (channel_in_num)
   ) u_vec_a (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .i_wr   (w_act_wr && !w_tgt),
      .i_clr  (w_drain_hs && !r_sel),
      .i_data (act_data),
      .o_vec  (w_vec_a),
      .o_full (w_full_a),
      .o_last (w_last_a)
   );

   layer2_word_packer #(
      .bits       (bits),
      .bits_shift (bits_shift),
      .lanes      (channel_in_num)
   ) u_vec_b (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .i_wr   (w_act_wr && w_tgt),
      .i_clr  (w_drain_hs && r_sel),
      .i_data (act_data),
      .o_vec  (w_vec_b),
      .o_full (w_full_b),
      .o_last (w_last_b)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         r_sel <= 1'b0;
      end else if (w_drain_hs) begin
         r_sel <= !r_sel;
      end
   end

   assign conv_data_in  = r_sel ? w_vec_b : w_vec_a;
   assign w_vec_room    = w_tgt ? !w_full_b : !w_full_a;
   assign w_fill_last   = (r_state == S_FILL) && (r_sel ? w_last_b : w_last_a);
   assign w_shadow_done = r_sel ? (w_full_a || w_last_a) : (w_full_b || w_last_b);
`else
   logic w_vfull;
   logic w_vlast;

   layer2_word_packer #(
      .bits       (bits),
      .bits_shift (bits_shift),
      .lanes      (channel_in_num)
   ) u_vec (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .i_wr   (w_act_wr),
      .i_clr  (w_drain_hs),
      .i_data (act_data),
      .o_vec  (conv_data_in),
      .o_full (w_vfull),
      .o_last (w_vlast)
   );

   assign w_vec_room    = !w_vfull;
   assign w_fill_last   = (r_state == S_FILL) && w_vlast;
   assign w_shadow_done = 1'b0;
`endif

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_pix_cnt    <= '0;
         r_out_data   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_frame_done <= w_drain_hs && w_pix_last;
         if ((r_state == S_IDLE) && (w_next == S_FILL)) begin
            r_pix_cnt <= '0;
         end else if (w_drain_hs && !w_pix_last) begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
         end
         if (r_state == S_CAPT) begin
            r_out_data <= conv_data_out;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      w_ready    = 1'b0;
      act_ready  = 1'b0;
      conv_start = 1'b0;
      out_valid  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            // rst_n gating keeps w_ready low while reset is held
            w_ready = rst_n && !w_wfull;
            if (frame_go && w_wfull && !w_wlast) begin
               w_next = S_FILL;
            end
         end
         S_FILL: begin
            act_ready = w_vec_room;
            if (w_fill_last) begin
               w_next = S_FIRE;
            end
         end
         S_FIRE: begin
            conv_start = 1'b1;
            act_ready  = OVERLAP && w_vec_room;
            w_next     = S_WAIT;
         end
         S_WAIT: begin
            act_ready = OVERLAP && w_vec_room;
            if (conv_ready) begin
               w_next = S_CAPT;
            end
         end
         S_CAPT: begin
            act_ready = OVERLAP && w_vec_room;
            w_next    = S_DRAIN;
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            act_ready = OVERLAP && w_vec_room;
            if (out_ready) begin
               if (w_pix_last) begin
                  w_next = S_IDLE;
               end else if (w_shadow_done) begin
                  w_next = S_FIRE;
               end else begin
                  w_next = S_FILL;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign out_data   = r_out_data;
   assign frame_done = r_frame_done;

endmodule
